// File: rtl/mem_size_unit.sv
// Sub-word load/store sequencer between the datapath and a fixed-latency word memory.
// Halfword and byte stores are done as read-modify-write of the containing word.
module mem_size_unit #(
    parameter int unsigned RD_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic [31:0] load_data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] OpSw    = 3'b100;
    localparam logic [2:0] CntInit = 3'(RD_LAT - 1);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] sdata_q, sdata_d;
    logic        err_q, err_d;
    logic [31:0] load_q, load_d;
    logic [31:0] wdata_q, wdata_d;

    logic        req_ok;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_ext;
    logic [31:0] merged;

    // op[1:0] encodes the access size; 2'b11 is never a legal size.
    always_comb begin
        unique case (op[1:0])
            2'b00:   req_ok = (addr[1:0] == 2'b00);
            2'b01:   req_ok = !addr[0];
            2'b10:   req_ok = 1'b1;
            default: req_ok = 1'b0;
        endcase
    end

    always_comb begin
        rd_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        rd_half = mem_rdata[{addr_q[1], 4'b0000} +: 16];
        unique case (op_q[1:0])
            2'b00:   load_ext = mem_rdata;
            2'b01:   load_ext = {16'b0, rd_half};
            default: load_ext = {24'b0, rd_byte};
        endcase
        merged = mem_rdata;
        if (op_q[1:0] == 2'b01) begin
            merged[{addr_q[1], 4'b0000} +: 16] = sdata_q;
        end else begin
            merged[{addr_q[1:0], 3'b000} +: 8] = sdata_q[7:0];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        sdata_d = sdata_q;
        err_d   = err_q;
        load_d  = load_q;
        wdata_d = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_d    = op;
                    addr_d  = addr;
                    sdata_d = store_data[15:0];
                    cnt_d   = CntInit;
                    err_d   = 1'b0;
                    if (!req_ok) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else if (op == OpSw) begin
                        wdata_d = store_data;
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else if (op_q[2]) begin
                    wdata_d = merged;
                    state_d = StWrite;
                end else begin
                    load_d  = load_ext;
                    state_d = StDone;
                end
            end
            StWrite: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            op_q    <= 3'd0;
            addr_q  <= 32'd0;
            sdata_q <= 16'd0;
            err_q   <= 1'b0;
            load_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            sdata_q <= sdata_d;
            err_q   <= err_d;
            load_q  <= load_d;
            wdata_q <= wdata_d;
        end
    end

    // In IDLE the address is passed through so memory can start fetching on the request cycle.
    assign mem_addr  = (state_q == StIdle) ? {addr[31:2], 2'b00} : {addr_q[31:2], 2'b00};
    assign mem_wr    = (state_q == StWrite);
    assign mem_wdata = wdata_q;
    assign load_data = load_q;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign err       = (state_q == StDone) && err_q;

endmodule

// File: tb/tb_mem_size_unit.sv
// Directed bench for mem_size_unit: three instances with RD_LAT = 1, 2, 3 share stimulus,
// each backed by its own word memory that returns data RD_LAT cycles after the address.
module tb_mem_size_unit;

    localparam int NumDut = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [NumDut-1:0] start_v;
    logic [2:0]        op;
    logic [31:0]       addr;
    logic [31:0]       store_data;

    logic [31:0] mem_rdata_w [NumDut];
    logic [31:0] mem_addr_w  [NumDut];
    logic [31:0] mem_wdata_w [NumDut];
    logic [31:0] load_data_w [NumDut];
    logic [31:0] mem_word_w  [NumDut];
    logic        mem_wr_w    [NumDut];
    logic        busy_w      [NumDut];
    logic        done_w      [NumDut];
    logic        err_w       [NumDut];

    logic        pre_we;
    logic [7:0]  pre_idx;
    logic [31:0] pre_data;
    logic [7:0]  chk_idx;

    int n_checks = 0;
    int n_errors = 0;

    int          done_n  [NumDut];
    int          done_c0 [NumDut];
    int          done_c1 [NumDut];
    int          stray   [NumDut];
    int          wr_n    [NumDut];
    int          wr_c    [NumDut];
    logic        err_d0  [NumDut];
    logic        busy1   [NumDut];
    logic        idle_busy [NumDut];
    logic [31:0] wr_d    [NumDut];
    logic [31:0] addr1   [NumDut];

    for (genvar g = 0; g < NumDut; g++) begin : g_dut
        logic [31:0] mem [256];
        logic [7:0]  apipe [4];

        mem_size_unit #(.RD_LAT(g + 1)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .start      (start_v[g]),
            .op         (op),
            .addr       (addr),
            .store_data (store_data),
            .mem_rdata  (mem_rdata_w[g]),
            .mem_addr   (mem_addr_w[g]),
            .mem_wr     (mem_wr_w[g]),
            .mem_wdata  (mem_wdata_w[g]),
            .load_data  (load_data_w[g]),
            .busy       (busy_w[g]),
            .done       (done_w[g]),
            .err        (err_w[g])
        );

        // Data for the address presented g+1 cycles ago.
        assign mem_rdata_w[g] = mem[apipe[g]];
        assign mem_word_w[g]  = mem[chk_idx];

        always @(posedge clk) begin
            apipe[0] <= mem_addr_w[g][9:2];
            for (int i = 1; i < 4; i++) apipe[i] <= apipe[i-1];
            if (mem_wr_w[g]) mem[mem_addr_w[g][9:2]] <= mem_wdata_w[g];
            else if (pre_we) mem[pre_idx] <= pre_data;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic clear_rec();
        for (int g = 0; g < NumDut; g++) begin
            done_n[g] = 0; done_c0[g] = 0; done_c1[g] = 0; stray[g] = 0;
            wr_n[g] = 0; wr_c[g] = 0; wr_d[g] = 32'h0; err_d0[g] = 1'b0;
            addr1[g] = 32'h0; busy1[g] = 1'b0; idle_busy[g] = 1'b1;
        end
    endtask

    task automatic sample(input int c);
        for (int g = 0; g < NumDut; g++) begin
            if (done_w[g]) begin
                done_n[g]++;
                if (done_n[g] == 1) begin
                    done_c0[g] = c;
                    err_d0[g]  = err_w[g];
                end else begin
                    done_c1[g] = c;
                end
            end
            if (err_w[g] && !done_w[g]) stray[g]++;
            if (mem_wr_w[g]) begin
                wr_n[g]++;
                wr_c[g] = c;
                wr_d[g] = mem_wdata_w[g];
            end
            if (c == 1) begin
                addr1[g] = mem_addr_w[g];
                busy1[g] = busy_w[g];
            end
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = a[9:2]; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // kind: 0 rejected request, 1 load, 2 SW, 3 SH/SB read-modify-write
    task automatic run_op(input string name, input logic [2:0] op_v, input logic [31:0] a,
                          input logic [31:0] sd, input int kind, input logic [31:0] exp_load,
                          input logic [31:0] exp_w);
        int lat;
        int exp_done;
        clear_rec();
        @(negedge clk);
        op = op_v; addr = a; store_data = sd; start_v = '1;
        @(negedge clk);
        start_v = '0;
        for (int c = 1; c <= 12; c++) begin
            sample(c);
            @(negedge clk);
        end
        chk_idx = a[9:2];
        #1;
        for (int g = 0; g < NumDut; g++) begin
            lat = g + 1;
            exp_done = (kind == 0) ? 1 : (kind == 1) ? lat + 1 : (kind == 2) ? 2 : lat + 2;
            check_eq($sformatf("%s/L%0d done_count", name, lat), done_n[g], 1);
            check_eq($sformatf("%s/L%0d done_cycle", name, lat), done_c0[g], exp_done);
            check_eq($sformatf("%s/L%0d err", name, lat), 32'(err_d0[g]), 32'(kind == 0));
            check_eq($sformatf("%s/L%0d stray_err", name, lat), stray[g], 0);
            check_eq($sformatf("%s/L%0d wr_count", name, lat), wr_n[g], 32'(kind >= 2));
            check_eq($sformatf("%s/L%0d busy_c1", name, lat), 32'(busy1[g]), 1);
            check_eq($sformatf("%s/L%0d mem_addr", name, lat), addr1[g], {a[31:2], 2'b00});
            check_eq($sformatf("%s/L%0d load_data", name, lat), load_data_w[g], exp_load);
            if (kind >= 2) begin
                check_eq($sformatf("%s/L%0d wr_cycle", name, lat), wr_c[g],
                         (kind == 2) ? 1 : lat + 1);
                check_eq($sformatf("%s/L%0d wr_data", name, lat), wr_d[g], exp_w);
                check_eq($sformatf("%s/L%0d mem_word", name, lat), mem_word_w[g], exp_w);
            end
        end
    endtask

    task automatic reset_abort();
        clear_rec();
        @(negedge clk);
        op = 3'b110; addr = 32'h0000_0100; store_data = 32'h0000_0077; start_v = '1;
        @(negedge clk);
        start_v = '0;
        for (int c = 1; c <= 10; c++) begin
            sample(c);
            if (c == 2) reset = 1'b1;
            if (c == 3) begin
                for (int g = 0; g < NumDut; g++) begin
                    check_eq($sformatf("rst/L%0d busy", g + 1), 32'(busy_w[g]), 0);
                    check_eq($sformatf("rst/L%0d mem_wr", g + 1), 32'(mem_wr_w[g]), 0);
                    check_eq($sformatf("rst/L%0d load_data", g + 1), load_data_w[g], 0);
                    check_eq($sformatf("rst/L%0d mem_wdata", g + 1), mem_wdata_w[g], 0);
                end
                reset = 1'b0;
            end
            @(negedge clk);
        end
        for (int g = 0; g < NumDut; g++) begin
            check_eq($sformatf("rst/L%0d done_count", g + 1), done_n[g], 0);
            // With RD_LAT=1 the second cycle is already WRITE, so its single write is legal.
            check_eq($sformatf("rst/L%0d wr_count", g + 1), wr_n[g], 32'(g == 0));
        end
    endtask

    task automatic held_start();
        int lat;
        clear_rec();
        @(negedge clk);
        op = 3'b000; addr = 32'h0000_0200; store_data = 32'h0; start_v = '1;
        @(negedge clk);
        op = 3'b100; addr = 32'h0000_0010; store_data = 32'h0BAD_F00D;
        for (int c = 1; c <= 14; c++) begin
            sample(c);
            for (int g = 0; g < NumDut; g++) begin
                if (c == g + 3) idle_busy[g] = busy_w[g];
                if (c == g + 5) start_v[g] = 1'b0;
            end
            @(negedge clk);
        end
        chk_idx = 8'h04;
        #1;
        for (int g = 0; g < NumDut; g++) begin
            lat = g + 1;
            check_eq($sformatf("b2b/L%0d done_count", lat), done_n[g], 2);
            check_eq($sformatf("b2b/L%0d done_lw", lat), done_c0[g], lat + 1);
            check_eq($sformatf("b2b/L%0d done_sw", lat), done_c1[g], lat + 4);
            check_eq($sformatf("b2b/L%0d idle_busy", lat), 32'(idle_busy[g]), 0);
            check_eq($sformatf("b2b/L%0d wr_count", lat), wr_n[g], 1);
            check_eq($sformatf("b2b/L%0d wr_cycle", lat), wr_c[g], lat + 3);
            check_eq($sformatf("b2b/L%0d wr_data", lat), wr_d[g], 32'h0BAD_F00D);
            check_eq($sformatf("b2b/L%0d mem_word", lat), mem_word_w[g], 32'h0BAD_F00D);
            check_eq($sformatf("b2b/L%0d load_data", lat), load_data_w[g], 32'hABCD_2222);
            check_eq($sformatf("b2b/L%0d busy_end", lat), 32'(busy_w[g]), 0);
        end
    endtask

    initial begin
        reset = 1'b1; start_v = '0; op = 3'b000; addr = 32'h0; store_data = 32'h0;
        pre_we = 1'b0; pre_idx = 8'h0; pre_data = 32'h0; chk_idx = 8'h0;
        repeat (3) @(negedge clk);
        preload(32'h0000_0100, 32'hA1B2_C3D4);
        preload(32'h0000_0200, 32'h1111_2222);
        preload(32'h0000_0010, 32'h0000_0000);
        preload(32'h0000_0004, 32'h5566_7788);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int g = 0; g < NumDut; g++) begin
            check_eq($sformatf("reset/L%0d mem_wr", g + 1), 32'(mem_wr_w[g]), 0);
            check_eq($sformatf("reset/L%0d busy", g + 1), 32'(busy_w[g]), 0);
            check_eq($sformatf("reset/L%0d done", g + 1), 32'(done_w[g]), 0);
            check_eq($sformatf("reset/L%0d err", g + 1), 32'(err_w[g]), 0);
            check_eq($sformatf("reset/L%0d load_data", g + 1), load_data_w[g], 0);
            check_eq($sformatf("reset/L%0d mem_wdata", g + 1), mem_wdata_w[g], 0);
        end
        addr = 32'h0000_0347;
        #1;
        for (int g = 0; g < NumDut; g++) begin
            check_eq($sformatf("idle/L%0d mem_addr", g + 1), mem_addr_w[g], 32'h0000_0344);
        end

        run_op("lb_102",  3'b010, 32'h0000_0102, 32'h0,         1, 32'h0000_00B2, 32'h0);
        run_op("sh_202",  3'b101, 32'h0000_0202, 32'h1234_ABCD, 3, 32'h0000_00B2, 32'hABCD_2222);
        run_op("sw_010",  3'b100, 32'h0000_0010, 32'hDEAD_BEEF, 2, 32'h0000_00B2, 32'hDEAD_BEEF);
        run_op("lw_006",  3'b000, 32'h0000_0006, 32'h0,         0, 32'h0000_00B2, 32'h0);
        run_op("op011",   3'b011, 32'h0000_0004, 32'h0,         0, 32'h0000_00B2, 32'h0);
        run_op("sh_201",  3'b101, 32'h0000_0201, 32'hFFFF_FFFF, 0, 32'h0000_00B2, 32'h0);
        run_op("lh_202",  3'b001, 32'h0000_0202, 32'h0,         1, 32'h0000_ABCD, 32'h0);
        run_op("sb_101",  3'b110, 32'h0000_0101, 32'hFFFF_FF5A, 3, 32'h0000_ABCD, 32'hA1B2_5AD4);
        run_op("lb_103",  3'b010, 32'h0000_0103, 32'h0,         1, 32'h0000_00A1, 32'h0);
        run_op("lw_100",  3'b000, 32'h0000_0100, 32'h0,         1, 32'hA1B2_5AD4, 32'h0);
        run_op("lh_200",  3'b001, 32'h0000_0200, 32'h0,         1, 32'h0000_2222, 32'h0);

        reset_abort();
        run_op("lw_post", 3'b000, 32'h0000_0200, 32'h0,         1, 32'hABCD_2222, 32'h0);
        held_start();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
